// File: rtl/pipe_pkg.sv
// pipe_pkg: shared column types and LFSR step for the pipe scroller.
package pipe_pkg;
  localparam int COL_W = 16;
  localparam int SEL_W = 3;
  typedef logic [COL_W-1:0] col_t;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register taps bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if: playfield control, pattern exchange and display/collision outputs.
interface pipe_scroller_if #(parameter int IDX_W = 4);
  import pipe_pkg::*;
  logic enable;
  logic clear;
  col_t col_data;
  logic [SEL_W-1:0] pipe_sel;
  logic scroll_tick;
  logic pipe_inserted;
  col_t bird_col_data;
  logic [IDX_W-1:0] disp_col_idx;
  col_t disp_col_data;
  modport master(output enable, clear, col_data,
                 input pipe_sel, scroll_tick, pipe_inserted, bird_col_data, disp_col_idx, disp_col_data);
  modport slave(input enable, clear, col_data,
                output pipe_sel, scroll_tick, pipe_inserted, bird_col_data, disp_col_idx, disp_col_data);
endinterface

// File: rtl/pipe_lfsr.sv
// pipe_lfsr: 8-bit pattern-select LFSR, advanced one step per step pulse.
module pipe_lfsr
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= seed;
    else if (step) q <= lfsr_next(q);
endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolling pipe playfield with LFSR pattern choice,
// bird-column tap and a free-running column scan for the LED driver.
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int         NCOLS      = 16,
  parameter int         TICK_DIV   = 4,
  parameter int         PIPE_WIDTH = 2,
  parameter int         PIPE_GAP   = 4,
  parameter int         BIRD_COL   = 3,
  parameter logic [7:0] SEED       = 8'h5A
) (
  input logic clk,
  input logic rst_n,
  pipe_scroller_if.slave bus
);
  localparam int IDX_W = $clog2(NCOLS);
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(PIPE_WIDTH + PIPE_GAP);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCOLS - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PIPE_WIDTH + PIPE_GAP - 1);
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] phase;
  col_t cols [NCOLS];
  logic [7:0] lfsr;
  logic [7:0] lfsr_nx;
  logic step;
  logic wrap;
  assign step = bus.enable && tick_cnt == TICK_LAST && !bus.clear;
  assign wrap = phase == PHASE_LAST;
  assign lfsr_nx = lfsr_next(lfsr);
  assign bus.bird_col_data = cols[BIRD_COL];
  pipe_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .step(step && wrap), .seed(SEED), .q(lfsr));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tick_cnt <= '0;
      phase <= '0;
      cols <= '{default: '0};
      bus.pipe_sel <= SEED[SEL_W-1:0];
      bus.scroll_tick <= 1'b0;
      bus.pipe_inserted <= 1'b0;
    end else begin
      bus.scroll_tick <= step;
      bus.pipe_inserted <= step && phase == '0;
      if (bus.clear) begin
        tick_cnt <= '0;
        phase <= '0;
        cols <= '{default: '0};
      end else if (bus.enable) begin
        tick_cnt <= step ? '0 : tick_cnt + 1'b1;
        if (step) begin
          for (int i = 0; i < NCOLS - 1; i++) cols[i] <= cols[i+1];
          cols[NCOLS-1] <= phase < PW'(PIPE_WIDTH) ? bus.col_data : '0;
          phase <= wrap ? '0 : phase + 1'b1;
          // new pattern is chosen only between pipes, so col_data is long settled
          if (wrap) bus.pipe_sel <= lfsr_nx[SEL_W-1:0];
        end
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.disp_col_idx <= '0;
      bus.disp_col_data <= '0;
    end else begin
      bus.disp_col_idx <= bus.disp_col_idx == IDX_LAST ? '0 : bus.disp_col_idx + 1'b1;
      bus.disp_col_data <= cols[bus.disp_col_idx];
    end
endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: scoreboard bench; expected tick responses are queued by the
// stimulus and checked by a negedge monitor alongside a scan-data model.
module tb_pipe_scroller;
  import pipe_pkg::*;
  typedef struct {
    logic       ins;
    col_t       bird;
    logic [2:0] sel;
    col_t       col;
    int         cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pipe_scroller_if #(.IDX_W(4)) bus ();
  pipe_scroller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic l_rst_n = 1'b0;
  logic l_step = 1'b0;
  logic [7:0] l_q;
  bit l_done = 1'b0;
  pipe_lfsr u_lfsr (.clk(clk), .rst_n(l_rst_n), .step(l_step), .seed(8'h5A), .q(l_q));
  int checks = 0;
  int errors = 0;
  int cyc;
  exp_t q[$];
  col_t m_buf [16];
  int m_idx;
  logic clear_q;
  col_t pat [4] = '{16'hF00F, 16'h0FF0, 16'h3C3C, 16'hF00F};
  logic [2:0] selt [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
  // coloum_pattern stand-in: a distinct column per select value
  always_comb
    bus.col_data = bus.pipe_sel == 3'b010 ? 16'hF00F :
                   bus.pipe_sel == 3'b100 ? 16'h0FF0 :
                   bus.pipe_sel == 3'b001 ? 16'h3C3C : 16'hDEAD;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic col_t colf(input int n);
    return (n > 0 && (n % 6 == 1 || n % 6 == 2)) ? pat[(n-1)/6] : '0;
  endfunction
  task automatic push_tick(input int n, input int c);
    q.push_back('{ins: n % 6 == 1, bird: n > 12 ? colf(n - 12) : '0, sel: selt[n/6], col: colf(n), cyc: c});
  endtask
  task automatic wait_tick();
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!bus.scroll_tick && k < 40);
    if (!bus.scroll_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no scroll_tick within 40 cycles (cycle %0d)", cyc);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_idx = 0;
      clear_q = 1'b0;
      foreach (m_buf[i]) m_buf[i] = '0;
    end else if (cyc > 0) begin
      chk("disp_col_data", bus.disp_col_data, m_buf[m_idx]);
      m_idx = (m_idx + 1) % 16;
      if (bus.scroll_tick) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_tick: scroll_tick 1 want 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("pipe_inserted", bus.pipe_inserted, e.ins);
          chk("bird_col_data", bus.bird_col_data, e.bird);
          chk("pipe_sel", bus.pipe_sel, e.sel);
          if (e.cyc > 0) chk("tick_cycle", cyc, e.cyc);
          for (int i = 0; i < 15; i++) m_buf[i] = m_buf[i+1];
          m_buf[15] = e.col;
        end
      end
      if (clear_q) foreach (m_buf[i]) m_buf[i] = '0;
      clear_q = bus.clear;
    end
  end
  initial begin
    bus.enable = 1'b0;
    bus.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scroll_tick", bus.scroll_tick, 0);
    chk("rst_inserted", bus.pipe_inserted, 0);
    chk("rst_bird", bus.bird_col_data, 0);
    chk("rst_pipe_sel", bus.pipe_sel, 3'b010);
    chk("rst_disp_idx", bus.disp_col_idx, 0);
    chk("rst_disp_data", bus.disp_col_data, 0);
    for (int n = 1; n <= 19; n++) push_tick(n, 4 * n);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    for (int n = 1; n <= 19; n++) wait_tick();
    bus.enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("freeze_pipe_sel", bus.pipe_sel, 3'b010);
    chk("freeze_bird", bus.bird_col_data, 16'h0FF0);
    chk("freeze_tick", bus.scroll_tick, 0);
    push_tick(20, 0);
    bus.enable = 1'b1;
    wait_tick();
    repeat (3) @(posedge clk);
    #1;
    bus.clear = 1'b1;
    for (int n = 21; n <= 26; n++)
      q.push_back('{ins: n == 21, bird: '0, sel: n == 26 ? 3'b100 : 3'b010,
                    col: n <= 22 ? 16'hF00F : 16'h0000, cyc: cyc + 1 + 4 * (n - 20)});
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    chk("clear_tick", bus.scroll_tick, 0);
    chk("clear_inserted", bus.pipe_inserted, 0);
    chk("clear_bird", bus.bird_col_data, 0);
    chk("clear_pipe_sel", bus.pipe_sel, 3'b010);
    for (int n = 21; n <= 26; n++) wait_tick();
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pipe_sel", bus.pipe_sel, 3'b010);
    chk("arst_tick", bus.scroll_tick, 0);
    chk("arst_disp_idx", bus.disp_col_idx, 0);
    chk("arst_disp_data", bus.disp_col_data, 0);
    chk("arst_bird", bus.bird_col_data, 0);
    for (int k = 0; k < 1000 && !l_done; k++) @(posedge clk);
    chk("lfsr_done", l_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    int per = 0;
    repeat (2) @(posedge clk);
    #1;
    l_rst_n = 1'b1;
    chk("lfsr_seed", l_q, 8'h5A);
    l_step = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      chk("lfsr_nonzero", l_q != 8'h00, 1);
      if (k == 1) chk("lfsr_step1", l_q, 8'hB4);
      if (k == 2) chk("lfsr_step2", l_q, 8'h69);
      if (l_q == 8'h5A && per == 0) per = k;
    end
    chk("lfsr_period", per, 255);
    l_step = 1'b0;
    l_done = 1'b1;
  end
endmodule
